dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data memory port between two requesters: the core's load/store path and a program/data loader port used for test loading and debug. Arbitration is fixed-priority to the core, with anti-starvation and burst rules for the loader. The block sits between the core's ALU/register-file load/store signals and the data memory. It drives a stall to the core whenever the core is denied access.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width
MAX_WAIT, 3, consecutive denied loader cycles before the loader is force-granted
MAX_BURST, 4, maximum consecutive loader grants while the core is also requesting

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
c_req  in  1  core access request
c_we  in  1  core write enable (1=store, 0=load)
c_ctrl  in  3  core size/sign control (DMCtrl encoding)
c_addr  in  ADDR_W  core address (ALU result)
c_wdata  in  DATA_W  core store data (rs2 value)
c_gnt  out  1  core granted this cycle (combinational)
c_rvalid  out  1  core read data valid
c_rdata  out  DATA_W  core read data
l_req, l_we, l_ctrl, l_addr, l_wdata  in  1/1/3/ADDR_W/DATA_W  loader request bundle, same meaning as the core bundle
l_gnt  out  1  loader granted this cycle
l_rvalid  out  1  loader read data valid
l_rdata  out  DATA_W  loader read data
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_we  out  1  memory write enable
m_ctrl  out  3  memory size/sign control
m_rdata  in  DATA_W  memory combinational read data
core_stall  out  1  c_req & ~c_gnt

Behaviour:
- Registered state:
  - owner: IDLE/CORE/LOADER
  - wait_cnt: 0..MAX_WAIT, saturating
  - burst_cnt: 0..MAX_BURST, saturating
  - response registers: c_rvalid, c_rdata, l_rvalid, l_rdata
- Reset (reset=0, asynchronous):
  - owner=IDLE, both counters 0.
  - c_rvalid, l_rvalid = 0; c_rdata, l_rdata = 0.
  - Any in-flight response is discarded.
- Grant, combinational in the same cycle; at most one grant per cycle:
  - Only c_req → core.
  - Only l_req → loader.
  - Both → loader if (owner==LOADER && burst_cnt<MAX_BURST) or wait_cnt>=MAX_WAIT; otherwise core.
  - Neither → no grant.
- Memory mux:
  - m_* follow the granted requester's bundle.
  - m_we = grant & we.
  - With no grant: m_we=0 and m_addr, m_wdata, m_ctrl = 0.
- Next-state updates:
  - owner ← CORE, LOADER or IDLE according to this cycle's grant.
  - wait_cnt: +1 when l_req & ~l_gnt (saturating); cleared when l_gnt=1 or l_req=0.
  - burst_cnt: +1 when l_gnt (saturating); cleared on any cycle without l_gnt.
- Read response:
  - One-cycle latency: a granted read (we=0) at cycle t gives rvalid=1 with rdata=m_rdata(t) at t+1 on that requester only.
  - rvalid is a one-cycle pulse.
  - rdata holds its last value while rvalid=0.
  - Writes produce no rvalid.
- Back-to-back grants to the same or different requesters are legal every cycle; there are no bubbles.
- Requester inputs are not latched. A denied requester must hold its bundle stable until granted.

Optional Feature:
DMEM_ARB_LOCK_EN
- Defined:
  - Adds input c_lock (1 bit).
  - While c_lock=1 and owner==CORE, c_req wins over l_req regardless of wait_cnt; wait_cnt still counts, saturating.
  - Used for atomic read-modify-write sequences.
- Undefined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset: assert reset=0 mid-cycle with a pending read → all rvalid/rdata go to 0 immediately; after release, owner=IDLE, and m_we=0 with no requests.
- Core read: c_req=1, c_we=0, c_addr=0x100, m_rdata=0xDEADBEEF → c_gnt=1 and m_addr=0x100 that cycle; c_rvalid=1, c_rdata=0xDEADBEEF next cycle; l_rvalid=0.
- Contention: c_req and l_req held at 1 from cycle 0 → core granted cycles 0–2; loader granted cycles 3–6 (wait reaches 3, then burst of 4); core granted cycle 7; core_stall=1 on cycles 3–6.
- Loader alone: l_req=1, l_we=1, l_addr=0x40, l_wdata=0x12345678 for 10 cycles → l_gnt=1 every cycle, m_we=1, m_wdata=0x12345678; burst_cnt saturates at 4 without a gap.
- Store/no-response: core store to 0x8 → m_we=1 for exactly one cycle; c_rvalid stays 0.
- Lock (DMEM_ARB_LOCK_EN): core granted with c_lock=1 and l_req=1 for 6 cycles → l_gnt=0 throughout. After c_lock drops, with wait_cnt saturated at 3, the loader is granted on the next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store path and the loader port.
// Grants are combinational and read data returns one cycle later. Optional macro: DMEM_ARB_LOCK_EN (adds c_lock).
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 3,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              reset,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              c_lock,
`endif
    input  logic              c_req,
    input  logic              c_we,
    input  logic [2:0]        c_ctrl,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [2:0]        l_ctrl,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_we,
    output logic [2:0]        m_ctrl,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              core_stall
);
    localparam int WAIT_W  = (MAX_WAIT  < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {OWN_IDLE = 2'd0, OWN_CORE = 2'd1, OWN_LOADER = 2'd2} owner_e;

    owner_e              owner_q, owner_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic                c_rvalid_q, c_rvalid_d;
    logic                l_rvalid_q, l_rvalid_d;
    logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]   l_rdata_q, l_rdata_d;
    logic                lock_hold;
    logic                loader_wins;

`ifdef DMEM_ARB_LOCK_EN
    assign lock_hold = c_lock && (owner_q == OWN_CORE);
`else
    assign lock_hold = 1'b0;
`endif

    // Loader only beats the core while continuing a burst or once it has starved long enough.
    assign loader_wins = !lock_hold &&
                         (((owner_q == OWN_LOADER) && (burst_cnt_q < BURST_MAX)) ||
                          (wait_cnt_q >= WAIT_MAX));
    assign c_gnt      = c_req && (!l_req || !loader_wins);
    assign l_gnt      = l_req && (!c_req || loader_wins);
    assign core_stall = c_req && !c_gnt;

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_we    = 1'b0;
        m_ctrl  = '0;
        if (c_gnt) begin
            m_addr  = c_addr;
            m_wdata = c_wdata;
            m_we    = c_we;
            m_ctrl  = c_ctrl;
        end else if (l_gnt) begin
            m_addr  = l_addr;
            m_wdata = l_wdata;
            m_we    = l_we;
            m_ctrl  = l_ctrl;
        end
    end

    always_comb begin
        owner_d     = c_gnt ? OWN_CORE : (l_gnt ? OWN_LOADER : OWN_IDLE);
        wait_cnt_d  = '0;
        burst_cnt_d = '0;
        if (l_req && !l_gnt) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + WAIT_W'(1);
        end
        if (l_gnt) begin
            burst_cnt_d = (burst_cnt_q >= BURST_MAX) ? BURST_MAX : burst_cnt_q + BURST_W'(1);
        end
        c_rvalid_d = c_gnt && !c_we;
        l_rvalid_d = l_gnt && !l_we;
        c_rdata_d  = c_rvalid_d ? m_rdata : c_rdata_q;
        l_rdata_d  = l_rvalid_d ? m_rdata : l_rdata_q;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_IDLE;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            c_rvalid_q  <= 1'b0;
            l_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            l_rdata_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            c_rvalid_q  <= c_rvalid_d;
            l_rvalid_q  <= l_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            l_rdata_q   <= l_rdata_d;
        end
    end

    assign c_rvalid = c_rvalid_q;
    assign l_rvalid = l_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic against a rule-level model,
// with read responses scoreboarded by an independent monitor.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int MB = 4;

    logic          CLK = 1'b0;
    logic          reset;
`ifdef DMEM_ARB_LOCK_EN
    logic          c_lock;
`endif
    logic          c_req, c_we, l_req, l_we;
    logic [2:0]    c_ctrl, l_ctrl;
    logic [AW-1:0] c_addr, l_addr;
    logic [DW-1:0] c_wdata, l_wdata;
    logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
    logic [DW-1:0] c_rdata, l_rdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_we;
    logic [2:0]    m_ctrl;
    logic          core_stall;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .reset(reset),
`ifdef DMEM_ARB_LOCK_EN
        .c_lock(c_lock),
`endif
        .c_req(c_req), .c_we(c_we), .c_ctrl(c_ctrl), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_ctrl(l_ctrl), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_ctrl(m_ctrl), .m_rdata(m_rdata),
        .core_stall(core_stall)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: who used the port last, how long the loader has waited, how long it has burst.
    int            mdl_owner;   // 0 none, 1 core, 2 loader
    int            mdl_wait;
    int            mdl_burst;
    logic [DW-1:0] c_exp_q[$];
    logic [DW-1:0] l_exp_q[$];
    logic [DW-1:0] c_last, l_last;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_grant(output bit cg, output bit lg);
        bit lw;
        lw = (mdl_owner == 2 && mdl_burst < MB) || (mdl_wait >= MW);
`ifdef DMEM_ARB_LOCK_EN
        if (c_lock && mdl_owner == 1) lw = 1'b0;
`endif
        cg = c_req && (!l_req || !lw);
        lg = l_req && (!c_req || lw);
    endfunction

    // Called at a negedge with inputs already set; returns at the following negedge.
    task automatic cycle(input logic [DW-1:0] rd, output bit dut_c, output bit dut_l);
        bit cg, lg;
        m_rdata = rd;
        model_grant(cg, lg);
        #2;
        dut_c = c_gnt;
        dut_l = l_gnt;
        chk("c_gnt", c_gnt, cg);
        chk("l_gnt", l_gnt, lg);
        chk("core_stall", core_stall, c_req && !cg);
        chk("m_we", m_we, cg ? c_we : (lg ? l_we : 1'b0));
        chk("m_addr", m_addr, cg ? c_addr : (lg ? l_addr : '0));
        chk("m_wdata", m_wdata, cg ? c_wdata : (lg ? l_wdata : '0));
        chk("m_ctrl", m_ctrl, cg ? c_ctrl : (lg ? l_ctrl : 3'd0));
        if (cg && !c_we) c_exp_q.push_back(rd);
        if (lg && !l_we) l_exp_q.push_back(rd);
        @(posedge CLK);
        mdl_owner = cg ? 1 : (lg ? 2 : 0);
        mdl_wait  = (l_req && !lg) ? ((mdl_wait + 1 > MW) ? MW : mdl_wait + 1) : 0;
        mdl_burst = lg ? ((mdl_burst + 1 > MB) ? MB : mdl_burst + 1) : 0;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_ctrl = '0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_we = 0; l_ctrl = '0; l_addr = '0; l_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
        c_lock = 0;
`endif
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        idle_inputs();
        mdl_owner = 0; mdl_wait = 0; mdl_burst = 0;
        c_exp_q.delete(); l_exp_q.delete();
        c_last = '0; l_last = '0;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
    endtask

    // Monitor: each response must appear exactly one cycle after its grant; otherwise rdata holds.
    always @(posedge CLK) begin
        logic [DW-1:0] e;
        #1;
        if (c_exp_q.size() > 0) begin
            e = c_exp_q.pop_front();
            chk("c_rvalid", c_rvalid, 1'b1);
            chk("c_rdata", c_rdata, e);
            c_last = e;
        end else begin
            chk("c_rvalid_idle", c_rvalid, 1'b0);
            chk("c_rdata_hold", c_rdata, c_last);
        end
        if (l_exp_q.size() > 0) begin
            e = l_exp_q.pop_front();
            chk("l_rvalid", l_rvalid, 1'b1);
            chk("l_rdata", l_rdata, e);
            l_last = e;
        end else begin
            chk("l_rvalid_idle", l_rvalid, 1'b0);
            chk("l_rdata_hold", l_rdata, l_last);
        end
    end

    initial begin
        bit gc, gl;
        m_rdata = '0;
        assert_reset();
        #3;
        chk("rst_c_rvalid", c_rvalid, 1'b0);
        chk("rst_l_rvalid", l_rvalid, 1'b0);
        chk("rst_m_we", m_we, 1'b0);
        release_reset();
        cycle(32'h1111_2222, gc, gl);

        // Core read, then reset while the response is still showing
        c_req = 1; c_we = 0; c_addr = 32'h100; c_ctrl = 3'd2;
        cycle(32'hDEAD_BEEF, gc, gl);
        chk("rd_c_gnt", gc, 1'b1);
        chk("rd_c_rvalid_next", c_rvalid, 1'b1);
        chk("rd_c_rdata_next", c_rdata, 32'hDEAD_BEEF);
        chk("rd_l_rvalid_next", l_rvalid, 1'b0);
        assert_reset();
        #1;
        chk("midrst_c_rvalid", c_rvalid, 1'b0);
        chk("midrst_c_rdata", c_rdata, '0);
        release_reset();
        cycle($urandom, gc, gl);

        // Contention: loader forced in at cycle 3, bursts 4, core back at 7
        c_req = 1; c_we = 0; c_addr = 32'h200;
        l_req = 1; l_we = 0; l_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            cycle($urandom, gc, gl);
            chk("cont_l_gnt", gl, (i >= 3 && i <= 6));
            chk("cont_c_gnt", gc, !(i >= 3 && i <= 6));
        end
        idle_inputs();
        cycle($urandom, gc, gl);

        // Loader alone for 10 cycles, then contention shows the burst count saturated
        l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            cycle($urandom, gc, gl);
            chk("ldr_l_gnt", gl, 1'b1);
        end
        c_req = 1; c_we = 1; c_addr = 32'h44;
        cycle($urandom, gc, gl);
        chk("ldr_sat_c_gnt", gc, 1'b1);
        idle_inputs();
        cycle($urandom, gc, gl);

        // Single core store, no response expected
        c_req = 1; c_we = 1; c_addr = 32'h8; c_wdata = 32'hCAFE_0001;
        cycle($urandom, gc, gl);
        idle_inputs();
        cycle($urandom, gc, gl);
        cycle($urandom, gc, gl);

`ifdef DMEM_ARB_LOCK_EN
        assert_reset();
        release_reset();
        c_req = 1; c_we = 0; c_addr = 32'h500; c_lock = 1;
        l_req = 1; l_we = 0; l_addr = 32'h600;
        for (int i = 0; i < 6; i++) begin
            cycle($urandom, gc, gl);
            chk("lock_l_gnt", gl, 1'b0);
        end
        c_lock = 0;
        cycle($urandom, gc, gl);
        chk("unlock_l_gnt", gl, 1'b1);
        idle_inputs();
        cycle($urandom, gc, gl);
`endif

        // Random traffic; a denied requester keeps its bundle until granted
        gc = 0; gl = 0;
        for (int i = 0; i < 400; i++) begin
            if (!c_req || gc) begin
                c_req = ($urandom % 3) != 0; c_we = $urandom % 2; c_ctrl = 3'($urandom);
                c_addr = $urandom; c_wdata = $urandom;
            end
            if (!l_req || gl) begin
                l_req = ($urandom % 2) != 0; l_we = $urandom % 2; l_ctrl = 3'($urandom);
                l_addr = $urandom; l_wdata = $urandom;
            end
`ifdef DMEM_ARB_LOCK_EN
            c_lock = ($urandom % 4) == 0;
`endif
            cycle($urandom, gc, gl);
        end
        idle_inputs();
        cycle($urandom, gc, gl);
        cycle($urandom, gc, gl);
        chk("c_queue_drained", c_exp_q.size(), 0);
        chk("l_queue_drained", l_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
